// File: rtl/keypad_code_lock.sv
// Keypad code lock: one-hot key encoder, press-edge detector, digit collector and code checker
// with failed-try lockout. Define KEYPAD_AUTO_UNLOCK_EN for a timed lockout; otherwise lockout holds until reset.
module keypad_code_lock #(
  parameter int N_KEYS      = 16,
  parameter int DIGITS      = 4,
  parameter int MAX_TRIES   = 5,
  parameter int LOCK_CYCLES = 50_000_000,
  parameter logic [N_KEYS*4-1:0] KEY_MAP = 64'h789F_456F_123F_0BAF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_KEYS-1:0]   onehot,
  input  logic [DIGITS*4-1:0] code,
  output logic                key_valid,
  output logic [3:0]          key_code,
  output logic [DIGITS*4-1:0] entry,
  output logic [3:0]          digit_cnt,
  output logic                match,
  output logic                fail,
  output logic [7:0]          tries,
  output logic                locked
);

  localparam int EW = DIGITS * 4;

  typedef enum logic [1:0] {
    ST_ENTRY  = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [N_KEYS-1:0] onehot_q;
  logic [3:0]        key_nib;
  logic              single_hot;
  logic              press;
  logic              key_evt;
  logic              is_digit;
  logic              is_clear;
  logic              is_enter;
  logic [EW-1:0]     digit_ext;
  logic              code_ok;
  logic [8:0]        tries_inc;
  logic              lock_now;

  // Key decode. With exactly one bit set the OR-reduction yields that key's map nibble.
  always_comb begin
    key_nib = 4'h0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (onehot[i]) key_nib = key_nib | KEY_MAP[i*4 +: 4];
    end
  end

  assign single_hot = (onehot != '0) && ((onehot & (onehot - N_KEYS'(1))) == '0);
  assign press      = single_hot && (onehot != onehot_q);
  assign key_evt    = press && (key_nib != 4'hF);
  assign is_digit   = key_evt && (key_nib <= 4'd9);
  assign is_enter   = key_evt && (key_nib == 4'hA);
  assign is_clear   = key_evt && (key_nib == 4'hB);

  always_comb begin
    digit_ext      = '0;
    digit_ext[3:0] = key_nib;
  end

  assign code_ok   = (entry == code) && (digit_cnt == 4'(DIGITS));
  assign tries_inc = {1'b0, tries} + 9'd1;
  assign lock_now  = (tries_inc >= 9'(MAX_TRIES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      onehot_q <= '0;
    end else begin
      onehot_q <= onehot;
    end
  end

  // key_valid is a one-cycle strobe with no back-pressure; key_code holds the last accepted key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid <= 1'b0;
      key_code  <= 4'h0;
    end else begin
      key_valid <= key_evt;
      if (key_evt) key_code <= key_nib;
    end
  end

`ifdef KEYPAD_AUTO_UNLOCK_EN
  localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  logic [LCW-1:0] lock_cnt;
  logic           lock_done;

  assign lock_done = (lock_cnt == '0);

  // Loaded with LOCK_CYCLES-1 on the entering edge so LOCKED lasts exactly LOCK_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt <= '0;
    end else if ((state == ST_CHECK) && (state_nxt == ST_LOCKED)) begin
      lock_cnt <= LCW'(LOCK_CYCLES - 1);
    end else if ((state == ST_LOCKED) && !lock_done) begin
      lock_cnt <= lock_cnt - LCW'(1);
    end
  end
`else
  logic unused_lock_cycles;
  assign unused_lock_cycles = (LOCK_CYCLES != 0);
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ENTRY;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ENTRY: begin
        if (is_enter) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (!code_ok && lock_now) state_nxt = ST_LOCKED;
        else                      state_nxt = ST_ENTRY;
      end
      ST_LOCKED: begin
`ifdef KEYPAD_AUTO_UNLOCK_EN
        if (lock_done) state_nxt = ST_ENTRY;
`endif
      end
      default: state_nxt = ST_ENTRY;
    endcase
  end

  // FSM outputs
  always_comb begin
    match  = 1'b0;
    fail   = 1'b0;
    locked = 1'b0;
    case (state)
      ST_CHECK: begin
        match = code_ok;
        fail  = !code_ok;
      end
      ST_LOCKED: locked = 1'b1;
      default: ;
    endcase
  end

  // Entry buffer and try counter. Key events outside ENTRY only affect key_valid/key_code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry     <= '0;
      digit_cnt <= 4'd0;
      tries     <= 8'd0;
    end else begin
      case (state)
        ST_ENTRY: begin
          if (is_clear) begin
            entry     <= '0;
            digit_cnt <= 4'd0;
          end else if (is_digit && (digit_cnt < 4'(DIGITS))) begin
            entry     <= (entry << 4) | digit_ext;
            digit_cnt <= digit_cnt + 4'd1;
          end
        end
        ST_CHECK: begin
          entry     <= '0;
          digit_cnt <= 4'd0;
          if (code_ok)              tries <= 8'd0;
          else if (tries != 8'hFF)  tries <= tries + 8'd1;
        end
        ST_LOCKED: begin
`ifdef KEYPAD_AUTO_UNLOCK_EN
          if (lock_done) tries <= 8'd0;
`endif
        end
        default: ;
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(match && fail));
      assert (digit_cnt <= 4'(DIGITS));
    end
  end
`endif

endmodule

// File: tb/tb_keypad_code_lock.sv
// Bench for keypad_code_lock: directed vector table, hand-written corner sequences and
// randomized key traffic checked every cycle against a queue-based reference model.
module tb_keypad_code_lock;

  localparam int DIGITS      = 4;
  localparam int MAX_TRIES   = 5;
  localparam int LOCK_CYCLES = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] onehot;
  logic [15:0] code;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] entry;
  logic [3:0]  digit_cnt;
  logic        match;
  logic        fail;
  logic [7:0]  tries;
  logic        locked;

  int checks = 0;
  int errors = 0;

  keypad_code_lock #(
    .N_KEYS(16), .DIGITS(DIGITS), .MAX_TRIES(MAX_TRIES), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .onehot(onehot), .code(code),
    .key_valid(key_valid), .key_code(key_code), .entry(entry), .digit_cnt(digit_cnt),
    .match(match), .fail(fail), .tries(tries), .locked(locked)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          digs[$];
  int          m_tries;
  bit          m_locked;
  int          m_left;
  int          m_lock_age;
  bit          m_check;
  bit          m_kv;
  logic [3:0]  m_kc;
  logic [15:0] m_prev;

  function automatic logic [3:0] key_of(input int pos);
    case (pos)
      3: return 4'h0;   7: return 4'h1;   6: return 4'h2;  5: return 4'h3;
      11: return 4'h4;  10: return 4'h5;  9: return 4'h6;  15: return 4'h7;
      14: return 4'h8;  13: return 4'h9;  1: return 4'hA;  2: return 4'hB;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [15:0] packed_entry();
    logic [15:0] v = 16'h0;
    foreach (digs[i]) v = (v << 4) | 16'(digs[i]);
    return v;
  endfunction

  function automatic bit entry_ok();
    return (digs.size() == DIGITS) && (packed_entry() == code);
  endfunction

  task automatic model_reset();
    digs.delete();
    m_tries = 0; m_locked = 0; m_left = 0; m_lock_age = 0;
    m_check = 0; m_kv = 0; m_kc = 4'h0; m_prev = 16'h0;
  endtask

  task automatic model_edge();
    bit         press;
    int         pos;
    logic [3:0] nib;
    bit         good;
    press = ($countones(onehot) == 1) && (onehot != m_prev);
    m_prev = onehot;
    pos = -1;
    for (int i = 0; i < 16; i++) if (onehot[i]) pos = i;
    nib = key_of(pos);
    m_kv = press && (nib != 4'hF);
    if (m_kv) m_kc = nib;
    if (m_check) begin
      good = entry_ok();
      if (good) m_tries = 0;
      else begin
        if (m_tries + 1 >= MAX_TRIES) begin
          m_locked = 1; m_left = LOCK_CYCLES; m_lock_age = 0;
        end
        m_tries = (m_tries + 1 > 255) ? 255 : m_tries + 1;
      end
      digs.delete();
      m_check = 0;
    end else if (m_locked) begin
      m_lock_age++;
`ifdef KEYPAD_AUTO_UNLOCK_EN
      m_left--;
      if (m_left == 0) begin
        m_locked = 0; m_tries = 0;
      end
`endif
    end else if (m_kv) begin
      if (nib <= 4'd9 && digs.size() < DIGITS) digs.push_back(int'(nib));
      else if (nib == 4'hB) digs.delete();
      else if (nib == 4'hA) m_check = 1;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    bit ok;
    ok = entry_ok();
    chk("key_valid", 32'(key_valid), 32'(m_kv));
    chk("key_code",  32'(key_code),  32'(m_kc));
    chk("entry",     32'(entry),     32'(packed_entry()));
    chk("digit_cnt", 32'(digit_cnt), 32'(digs.size()));
    chk("match",     32'(match),     32'(m_check && ok));
    chk("fail",      32'(fail),      32'(m_check && !ok));
    chk("tries",     32'(tries),     32'(m_tries));
    chk("locked",    32'(locked),    32'(m_locked));
  endtask

  // ---------------- drivers (entered and left at a negedge) ----------------
  task automatic tick(input logic [15:0] oh, input logic [15:0] cd);
    compare_model();
    onehot = oh;
    code   = cd;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_key_valid", 32'(key_valid), 0);
    chk("rst_key_code",  32'(key_code),  0);
    chk("rst_entry",     32'(entry),     0);
    chk("rst_digit_cnt", 32'(digit_cnt), 0);
    chk("rst_match",     32'(match),     0);
    chk("rst_fail",      32'(fail),      0);
    chk("rst_tries",     32'(tries),     0);
    chk("rst_locked",    32'(locked),    0);
    model_reset();
    onehot = 16'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [15:0] oh;
    logic [15:0] cd;
    logic        kv;
    logic [3:0]  kc;
    logic [15:0] ent;
    logic [3:0]  cnt;
    logic        mt;
    logic        fl;
    logic [7:0]  tr;
  } vec_t;

  vec_t tbl[16];

  int dbits[10] = '{3, 7, 6, 5, 11, 10, 9, 15, 14, 13};
  logic [15:0] good_seq[12] = '{16'h0004, 16'h0, 16'h0080, 16'h0, 16'h0040, 16'h0,
                                16'h0020, 16'h0, 16'h0800, 16'h0, 16'h0002, 16'h0};

  initial begin
    int          n;
    int          kv_cnt;
    logic [15:0] oh;
    logic [15:0] cd;
    int          r;

    rst_n  = 1'b0;
    onehot = 16'h0;
    code   = 16'h0;
    @(negedge clk);
    do_reset();

    // ---- table-driven directed vectors ----
    tbl[0]  = '{16'h0008, 16'h0123, 1'b1, 4'h0, 16'h0000, 4'd1, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{16'h0080, 16'h0123, 1'b1, 4'h1, 16'h0001, 4'd2, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{16'h0040, 16'h0123, 1'b1, 4'h2, 16'h0012, 4'd3, 1'b0, 1'b0, 8'd0};
    tbl[3]  = '{16'h0020, 16'h0123, 1'b1, 4'h3, 16'h0123, 4'd4, 1'b0, 1'b0, 8'd0};
    tbl[4]  = '{16'h0002, 16'h0123, 1'b1, 4'hA, 16'h0123, 4'd4, 1'b1, 1'b0, 8'd0};
    tbl[5]  = '{16'h0002, 16'h0123, 1'b0, 4'hA, 16'h0000, 4'd0, 1'b0, 1'b0, 8'd0};
    tbl[6]  = '{16'h0080, 16'h0123, 1'b1, 4'h1, 16'h0001, 4'd1, 1'b0, 1'b0, 8'd0};
    tbl[7]  = '{16'h0080, 16'h0123, 1'b0, 4'h1, 16'h0001, 4'd1, 1'b0, 1'b0, 8'd0};
    tbl[8]  = '{16'h0000, 16'h0123, 1'b0, 4'h1, 16'h0001, 4'd1, 1'b0, 1'b0, 8'd0};
    tbl[9]  = '{16'h0080, 16'h0123, 1'b1, 4'h1, 16'h0011, 4'd2, 1'b0, 1'b0, 8'd0};
    tbl[10] = '{16'h00C0, 16'h0123, 1'b0, 4'h1, 16'h0011, 4'd2, 1'b0, 1'b0, 8'd0};
    tbl[11] = '{16'h0001, 16'h0123, 1'b0, 4'h1, 16'h0011, 4'd2, 1'b0, 1'b0, 8'd0};
    tbl[12] = '{16'h0004, 16'h0123, 1'b1, 4'hB, 16'h0000, 4'd0, 1'b0, 1'b0, 8'd0};
    tbl[13] = '{16'h0020, 16'h0123, 1'b1, 4'h3, 16'h0003, 4'd1, 1'b0, 1'b0, 8'd0};
    tbl[14] = '{16'h0002, 16'h0123, 1'b1, 4'hA, 16'h0003, 4'd1, 1'b0, 1'b1, 8'd0};
    tbl[15] = '{16'h0000, 16'h0123, 1'b0, 4'hA, 16'h0000, 4'd0, 1'b0, 1'b0, 8'd1};
    for (int i = 0; i < 16; i++) begin
      onehot = tbl[i].oh;
      code   = tbl[i].cd;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_key_valid", i), 32'(key_valid), 32'(tbl[i].kv));
      chk($sformatf("vec%0d_key_code", i),  32'(key_code),  32'(tbl[i].kc));
      chk($sformatf("vec%0d_entry", i),     32'(entry),     32'(tbl[i].ent));
      chk($sformatf("vec%0d_digit_cnt", i), 32'(digit_cnt), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d_match", i),     32'(match),     32'(tbl[i].mt));
      chk($sformatf("vec%0d_fail", i),      32'(fail),      32'(tbl[i].fl));
      chk($sformatf("vec%0d_tries", i),     32'(tries),     32'(tbl[i].tr));
      chk($sformatf("vec%0d_locked", i),    32'(locked),    0);
    end
    do_reset();

    // ---- held key: single pulse, release and re-press: second pulse ----
    kv_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick(16'h0080, 16'h1234);
      if (key_valid === 1'b1) kv_cnt++;
    end
    chk("hold_pulses", 32'(kv_cnt), 1);
    tick(16'h0000, 16'h1234);
    tick(16'h0080, 16'h1234);
    chk("repress_pulse", 32'(key_valid), 1);
    tick(16'h0000, 16'h1234);
    do_reset();

    // ---- five digits (fifth dropped) then enter; then 1,2,B clears ----
    tick(16'h0080, 16'h1234); tick(16'h0, 16'h1234);
    tick(16'h0040, 16'h1234); tick(16'h0, 16'h1234);
    tick(16'h0020, 16'h1234); tick(16'h0, 16'h1234);
    tick(16'h0800, 16'h1234); tick(16'h0, 16'h1234);
    tick(16'h0400, 16'h1234); tick(16'h0, 16'h1234);
    chk("five_digit_cnt", 32'(digit_cnt), 4);
    chk("five_entry",     32'(entry),     32'h1234);
    tick(16'h0002, 16'h1234);
    chk("five_match", 32'(match), 1);
    tick(16'h0, 16'h1234);
    tick(16'h0080, 16'h1234); tick(16'h0040, 16'h1234);
    chk("partial_entry", 32'(entry), 32'h0012);
    tick(16'h0004, 16'h1234);
    chk("clear_entry", 32'(entry), 0);
    chk("clear_cnt",   32'(digit_cnt), 0);

    // ---- reset asserted mid-entry clears everything immediately ----
    tick(16'h0080, 16'h1234); tick(16'h0040, 16'h1234);
    do_reset();

    // ---- five wrong codes lead to lockout ----
    for (int a = 1; a <= MAX_TRIES; a++) begin
      for (int d = 0; d < 4; d++) begin
        tick(16'h2000, 16'h1234);
        tick(16'h0000, 16'h1234);
      end
      tick(16'h0002, 16'h1234);
      chk($sformatf("lock_fail%0d", a), 32'(fail), 1);
      tick(16'h0000, 16'h1234);
      chk($sformatf("lock_tries%0d", a), 32'(tries), 32'(a));
      chk($sformatf("lock_state%0d", a), 32'(locked), 32'(a == MAX_TRIES));
    end
`ifdef KEYPAD_AUTO_UNLOCK_EN
    n = 0;
    while (locked === 1'b1 && n < 40) begin
      n++;
      tick(n[0] ? 16'h0080 : 16'h0000, 16'h1234);
    end
    chk("unlock_len",   32'(n),      32'(LOCK_CYCLES));
    chk("unlock_tries", 32'(tries),  0);
    chk("unlock_state", 32'(locked), 0);
`else
    for (int i = 0; i < 20; i++) tick(i[0] ? 16'h0002 : 16'h0080, 16'h1234);
    chk("hold_locked", 32'(locked),    1);
    chk("hold_tries",  32'(tries),     32'(MAX_TRIES));
    chk("hold_cnt",    32'(digit_cnt), 0);
`endif
    do_reset();

    // ---- randomized traffic against the reference model ----
    oh = 16'h0;
    for (int it = 0; it < 2500; it++) begin
      if (m_locked && m_lock_age > 12) do_reset();
      cd = ($urandom_range(0, 3) != 0) ? 16'h1234
         : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
            4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      if ($urandom_range(0, 15) == 0) begin
        foreach (good_seq[k]) tick(good_seq[k], 16'h1234);
        oh = 16'h0;
      end else begin
        r = $urandom_range(0, 11);
        case (r)
          0:        oh = 16'h0000;
          1:        oh = 16'h0080;
          2:        oh = 16'h0040;
          3:        oh = 16'h0020;
          4:        oh = 16'h0800;
          5:        oh = 16'h1 << dbits[$urandom_range(0, 9)];
          6:        oh = 16'h0002;
          7:        oh = 16'h0004;
          8:        oh = 16'($urandom());
          9:        oh = 16'h1 << $urandom_range(0, 15);
          default:  ;
        endcase
        tick(oh, cd);
      end
    end
    compare_model();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
